// File: rtl/dmem_responder.sv
// Tagged fixed-latency data memory: accepts at most one LOAD/STORE per cycle
// and returns in-order completions MEM_LATENCY cycles after acceptance.
module dmem_responder #(
  parameter int MEM_LATENCY = 10,
  parameter int MEM_WORDS   = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [3:0]  mem2proc_tag,
  output logic [63:0] mem2proc_data
);
  localparam int NSLOT = 15;
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic [63:0] r_mem [MEM_WORDS];
  logic [63:0] r_rd_data;
  logic        r_fill_valid;
  logic [3:0]  r_fill_slot;
  logic [3:0]  r_tag;
  logic [63:0] r_data;

  logic             w_is_load;
  logic             w_is_store;
  logic             w_in_range;
  logic             w_accept;
  logic             w_free_any;
  logic [3:0]       w_free_idx;
  logic [AW-1:0]    w_widx;
  logic [NSLOT-1:0] w_busy;
  logic [NSLOT-1:0] w_count_one;
  logic [NSLOT-1:0] w_slot_load;
  logic [63:0]      w_slot_data [NSLOT];
  logic [3:0]       w_done_tag;
  logic [63:0]      w_done_data;
  logic             w_unused_addr;

  assign w_is_load     = (proc2mem_command == CMD_LOAD);
  assign w_is_store    = (proc2mem_command == CMD_STORE);
  assign w_in_range    = (proc2mem_addr[63:3] < 61'(MEM_WORDS));
  assign w_widx        = proc2mem_addr[3 +: AW];
  assign w_unused_addr = ^proc2mem_addr[2:0];

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!w_busy[i]) begin
        w_free_any = 1'b1;
        w_free_idx = 4'(i);
      end
    end
  end

  assign w_accept = reset && (w_is_load || w_is_store) && w_in_range && w_free_any;
  assign mem2proc_response = w_accept ? (w_free_idx + 4'd1) : 4'd0;

  // Storage is never reset; the load snapshot is a registered read-before-write.
  always_ff @(posedge clock) begin
    if (w_accept && w_is_store) begin
      r_mem[w_widx] <= proc2mem_data;
    end
    if (w_accept && w_is_load) begin
      r_rd_data <= r_mem[w_widx];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fill_valid <= 1'b0;
      r_fill_slot  <= '0;
    end else begin
      r_fill_valid <= w_accept && w_is_load;
      r_fill_slot  <= w_free_idx;
    end
  end

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    logic        r_busy;
    logic [5:0]  r_count;
    logic        r_load;
    logic [63:0] r_sdata;
    logic        w_alloc;
    logic        w_filling;

    assign w_alloc   = w_accept && (w_free_idx == 4'(gi));
    assign w_filling = r_fill_valid && (r_fill_slot == 4'(gi));

    always_ff @(posedge clock) begin
      if (!reset) begin
        r_busy  <= 1'b0;
        r_count <= '0;
        r_load  <= 1'b0;
      end else if (w_alloc) begin
        r_busy  <= 1'b1;
        r_count <= 6'(MEM_LATENCY);
        r_load  <= w_is_load;
      end else if (r_busy) begin
        // Count of zero means the tag is on the output now; release it next edge.
        if (r_count == 6'd0) begin
          r_busy <= 1'b0;
        end else begin
          r_count <= r_count - 6'd1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (w_filling) begin
        r_sdata <= r_rd_data;
      end
    end

    assign w_busy[gi]      = r_busy;
    assign w_count_one[gi] = r_busy && (r_count == 6'd1);
    assign w_slot_load[gi] = r_load;
    assign w_slot_data[gi] = w_filling ? r_rd_data : r_sdata;
  end

  always_comb begin
    w_done_tag  = '0;
    w_done_data = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (w_count_one[i]) begin
        w_done_tag  = 4'(i + 1);
        w_done_data = w_slot_load[i] ? w_slot_data[i] : 64'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tag  <= '0;
      r_data <= '0;
    end else begin
      r_tag  <= w_done_tag;
      r_data <= w_done_data;
    end
  end

  assign mem2proc_tag  = r_tag;
  assign mem2proc_data = r_data;
endmodule
